// File: rtl/sfq_not_scheduler_if.sv
// rtl/sfq_not_scheduler_if.sv - request/response handshake bundle for sfq_not_scheduler
// Requesters sit on the master side; the scheduler is the slave that grants and answers.
interface sfq_not_scheduler_if #(
   parameter int N_REQ = 4
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_data;
   logic [N_REQ-1:0] req_ready;
   logic             rsp_valid;
   logic [ID_W-1:0]  rsp_id;
   logic             rsp_data;
   logic             rsp_err;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready,
      input  rsp_valid,
      input  rsp_id,
      input  rsp_data,
      input  rsp_err
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready,
      output rsp_valid,
      output rsp_id,
      output rsp_data,
      output rsp_err
   );
endinterface

// File: rtl/sfq_not_scheduler.sv
// rtl/sfq_not_scheduler.sv - round-robin sharing of one clocked SFQ NOT cell
// Sequences data/clock pulses to the cell, counts output pulses in a window, answers the winner.
module sfq_not_scheduler #(
   parameter int N_REQ      = 4,
   parameter int SETUP_CYC  = 2,
   parameter int WINDOW_CYC = 3
) (
   input  logic               clk,
   input  logic               rst,
   sfq_not_scheduler_if.slave bus,
   output logic               err_stray,
   output logic               cell_in,
   output logic               cell_clk,
   input  logic               cell_out
);
   localparam int ID_W    = $clog2(N_REQ);
   localparam int MAX_CYC = (SETUP_CYC > WINDOW_CYC) ? SETUP_CYC : WINDOW_CYC;
   localparam int TMR_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

   localparam logic [TMR_W-1:0] SETUP_LOAD  = TMR_W'(SETUP_CYC - 1);
   localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW_CYC - 1);

   typedef enum logic [2:0] {
      FLUSH,
      FLUSH_WAIT,
      IDLE,
      DATA,
      SETUP,
      CLOCK,
      WATCH,
      RESP
   } state_t;

   state_t           state;
   logic [ID_W-1:0]  ptr;
   logic [TMR_W-1:0] tmr;
   logic [1:0]       hits;
   logic [ID_W-1:0]  id_q;

   logic             cell_in_q;
   logic             cell_clk_q;
   logic             rsp_valid_q;
   logic [ID_W-1:0]  rsp_id_q;
   logic             rsp_data_q;
   logic             rsp_err_q;

   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  win_idx;
   logic [ID_W-1:0]  scan;
   logic [ID_W-1:0]  ptr_nx;
   logic             any_req;
   logic [1:0]       hits_nx;
   logic             stray_zone;

   // First valid index at or after the pointer, wrapping at N_REQ-1.
   always_comb begin
      grant   = '0;
      win_idx = '0;
      scan    = '0;
      any_req = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         scan = ID_W'((int'(ptr) + k) % N_REQ);
         if (!any_req && bus.req_valid[scan]) begin
            any_req = 1'b1;
            win_idx = scan;
         end
      end
      if (any_req && state == IDLE) begin
         grant[win_idx] = 1'b1;
      end
   end

   assign ptr_nx     = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
   assign hits_nx    = (cell_out && hits != 2'd3) ? hits + 2'd1 : hits;
   assign stray_zone = (state == IDLE) || (state == DATA) || (state == SETUP) ||
                       (state == CLOCK) || (state == RESP);

   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign cell_in       = cell_in_q;
   // The flush pulse must appear in the very first cycle after reset release,
   // before any register has seen rst low, so it is decoded from the state.
   assign cell_clk      = cell_clk_q | (state == FLUSH && !rst);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FLUSH;
         ptr         <= '0;
         tmr         <= '0;
         hits        <= '0;
         id_q        <= '0;
         cell_in_q   <= 1'b0;
         cell_clk_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         err_stray   <= 1'b0;
      end else begin
         cell_in_q   <= 1'b0;
         cell_clk_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         if (cell_out && stray_zone) begin
            err_stray <= 1'b1;
         end
         case (state)
            FLUSH: begin
               state <= FLUSH_WAIT;
               tmr   <= WINDOW_LOAD;
            end
            FLUSH_WAIT: begin
               if (tmr == '0) begin
                  state <= IDLE;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            IDLE: begin
               if (any_req) begin
                  state     <= DATA;
                  ptr       <= ptr_nx;
                  id_q      <= win_idx;
                  cell_in_q <= bus.req_data[win_idx];
               end
            end
            DATA: begin
               state <= SETUP;
               tmr   <= SETUP_LOAD;
            end
            SETUP: begin
               if (tmr == '0) begin
                  state      <= CLOCK;
                  cell_clk_q <= 1'b1;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            CLOCK: begin
               state <= WATCH;
               tmr   <= WINDOW_LOAD;
               hits  <= '0;
            end
            WATCH: begin
               hits <= hits_nx;
               // Last window cycle: the result already includes this cycle's sample.
               if (tmr == '0) begin
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= id_q;
                  rsp_data_q  <= (hits_nx == 2'd1);
                  rsp_err_q   <= (hits_nx >= 2'd2);
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= FLUSH;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sfq_not_scheduler.sv
// tb/tb_sfq_not_scheduler.sv - randomized self-checking bench for sfq_not_scheduler
// Expected behaviour is derived from cycle offsets relative to each transfer.
module tb_sfq_not_scheduler;
   localparam int N_REQ = 4;
   localparam int S     = 2;
   localparam int W     = 3;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic cell_out = 1'b0;
   logic err_stray;
   logic cell_in;
   logic cell_clk;

   sfq_not_scheduler_if #(.N_REQ(N_REQ)) bus ();

   sfq_not_scheduler #(
      .N_REQ      (N_REQ),
      .SETUP_CYC  (S),
      .WINDOW_CYC (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .err_stray (err_stray),
      .cell_in   (cell_in),
      .cell_clk  (cell_clk),
      .cell_out  (cell_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int rel       = 0;
   int m_ptr     = 0;
   int busy_till = W + 1;
   int t_act     = -1;
   int t_id      = 0;
   int hits      = 0;
   bit t_data    = 1'b0;
   bit m_stray   = 1'b0;
   bit prev_rst  = 1'b0;
   int xfers     = 0;
   int rsps      = 0;
   int mode      = 0;
   bit stray_en  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", tag, got, exp, rel);
      end
   endtask

   task automatic step(input bit r);
      logic [N_REQ-1:0] v;
      logic [N_REQ-1:0] d;
      logic [N_REQ-1:0] e_ready;
      bit in_win;
      bit flush_zone;
      bit e_rsp;
      int idx;
      v          = '0;
      d          = '0;
      in_win     = 1'b0;
      flush_zone = 1'b0;
      rst        = r;
      if (r) begin
         cell_out = 1'b0;
      end else begin
         case (mode)
            0:       v = '1;
            1:       v = N_REQ'($urandom);
            2:       v = 4'b1000;
            default: v = '0;
         endcase
         d          = N_REQ'($urandom);
         in_win     = (t_act >= 0) && (rel >= t_act + 3 + S) && (rel <= t_act + 2 + S + W);
         flush_zone = (rel <= W);
         if (in_win)
            cell_out = 1'($urandom_range(0, 1));
         else if (flush_zone)
            cell_out = ($urandom_range(0, 2) == 0);
         else
            cell_out = stray_en && ($urandom_range(0, 24) == 0);
         if (in_win && cell_out) hits++;
      end
      bus.req_valid = v;
      bus.req_data  = d;
      @(negedge clk);
      if (r) begin
         if (prev_rst) begin
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_rsp_id", bus.rsp_id, 0);
            check("rst_rsp_data", bus.rsp_data, 0);
            check("rst_rsp_err", bus.rsp_err, 0);
            check("rst_cell_in", cell_in, 0);
            check("rst_cell_clk", cell_clk, 0);
            check("rst_err_stray", err_stray, 0);
         end
         m_ptr     = 0;
         t_act     = -1;
         m_stray   = 1'b0;
         rel       = 0;
         busy_till = W + 1;
      end else begin
         e_ready = '0;
         idx     = -1;
         if (rel >= busy_till) begin
            for (int k = 0; k < N_REQ; k++) begin
               if (idx < 0 && v[(m_ptr + k) % N_REQ]) idx = (m_ptr + k) % N_REQ;
            end
         end
         if (idx >= 0) e_ready[idx] = 1'b1;
         e_rsp = (t_act >= 0) && (rel == t_act + 3 + S + W);
         check("req_ready", bus.req_ready, e_ready);
         check("cell_in", cell_in, (t_act >= 0) && (rel == t_act + 1) && t_data);
         check("cell_clk", cell_clk, (rel == 0) || ((t_act >= 0) && (rel == t_act + 2 + S)));
         check("rsp_valid", bus.rsp_valid, e_rsp);
         check("rsp_id", bus.rsp_id, e_rsp ? t_id : 0);
         check("rsp_data", bus.rsp_data, e_rsp && (hits == 1));
         check("rsp_err", bus.rsp_err, e_rsp && (hits >= 2));
         check("err_stray", err_stray, m_stray);
         if (cell_out && !in_win && !flush_zone) m_stray = 1'b1;
         if (e_rsp) begin
            t_act = -1;
            rsps++;
         end
         if (idx >= 0) begin
            t_act     = rel;
            t_id      = idx;
            t_data    = d[idx];
            hits      = 0;
            m_ptr     = (idx + 1) % N_REQ;
            busy_till = rel + 4 + S + W;
            xfers++;
         end
         rel++;
      end
      prev_rst = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      @(posedge clk);
      #1;
      repeat (3) step(1'b1);

      // All requesters valid: five grants 0,1,2,3,0 leave the pointer at 1.
      mode = 0;
      repeat (49) step(1'b0);
      // Only requester 3 valid from pointer 1.
      mode = 2;
      repeat (30) step(1'b0);
      mode = 1;
      repeat (150) step(1'b0);

      // Abort a transaction in its SETUP phase.
      for (int i = 0; i < 100 && !(t_act >= 0 && rel == t_act + 3); i++) step(1'b0);
      check("abort_point_reached", (t_act >= 0) && (rel == t_act + 3), 1);
      repeat (3) step(1'b1);
      repeat (20) step(1'b0);

      mode     = 1;
      stray_en = 1'b1;
      repeat (200) step(1'b0);
      mode = 3;
      repeat (20) step(1'b0);

      repeat (2) step(1'b1);
      mode     = 1;
      stray_en = 1'b0;
      repeat (100) step(1'b0);

      check("transfers_seen", xfers > 20, 1);
      check("responses_seen", rsps > 20, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule

// File: doc/sfq_not_scheduler.md
# sfq_not_scheduler

Round-robin scheduler that shares one clocked SFQ NOT cell (mitll_not-style: `in`, `clk`, `out`) among `N_REQ` requesters. It accepts one bit per transaction, sequences the cell's data and clock pulses with programmed spacing, and watches the cell output in a fixed window. It returns the inverted bit, or an error, to the winning requester. It sits between the digital control fabric and the cell wrapper in the test harness.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8.
- `SETUP_CYC`, 2 — idle cycles between the data pulse slot and the clock pulse, ≥1.
- `WINDOW_CYC`, 3 — cycles `cell_out` is sampled after the clock pulse, ≥1.
- `clk` input 1 — system clock; all logic on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `req_valid` input N_REQ — per-requester request.
- `req_data` input N_REQ — per-requester bit to invert.
- `req_ready` output N_REQ — one-hot grant; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid` output 1 — one-cycle response strobe; there is no backpressure.
- `rsp_id` output clog2(N_REQ) — index of the requester being answered.
- `rsp_data` output 1 — result bit (NOT of the request).
- `rsp_err` output 1 — the window contained two or more output pulses.
- `err_stray` output 1 — sticky flag for an output pulse seen outside any window; cleared only by `rst`.
- `cell_in` output 1 — data pulse to the cell, one cycle wide.
- `cell_clk` output 1 — clock pulse to the cell, one cycle wide.
- `cell_out` input 1 — cell output, already synchronized; each cycle it is high counts as one pulse.

## Operation
- Cell semantics relied on:
  - A clock pulse with no preceding data pulse yields one output pulse.
  - A data pulse followed by a clock pulse yields none.
  - A second data pulse before the clock is forbidden; the controller never issues one.
- States and transitions:
  - FLUSH → FLUSH_WAIT → IDLE. FLUSH issues `cell_clk` for one cycle; FLUSH_WAIT runs WINDOW_CYC cycles; `cell_out` is ignored throughout.
  - IDLE → DATA on transfer.
  - DATA (1 cycle) → SETUP (SETUP_CYC cycles) → CLOCK (1 cycle) → WATCH (WINDOW_CYC cycles) → RESP (1 cycle) → IDLE.
- Arbitration:
  - `req_ready` is nonzero only in IDLE. It is combinational from `req_valid` and the round-robin pointer.
  - The grant goes to the first valid index at or after the pointer, wrapping from N_REQ-1 to 0.
  - On a transfer the pointer becomes winner+1 (mod N_REQ). With no valid requests, `req_ready` is 0 and the pointer holds.
- `req_data[winner]` and the winner index are registered at transfer.
- DATA cycle: `cell_in` = registered data. CLOCK cycle: `cell_clk` = 1.
- WATCH: a 2-bit saturating counter counts cycles with `cell_out`=1.
- RESP outputs, with count 0/1/≥2:
  - `rsp_valid`=1 and `rsp_id` = winner.
  - `rsp_data` = 0/1/0.
  - `rsp_err` = 0/0/1.
- `cell_out`=1 in IDLE, DATA, SETUP, CLOCK or RESP sets `err_stray`. It has no other effect.

## Timing
- Reset values:
  - all outputs 0;
  - round-robin pointer 0;
  - state FLUSH on the first cycle with `rst`=0.
- Flush: `cell_clk` is high in the first cycle after reset release. IDLE is reached WINDOW_CYC+1 cycles later; first possible grant at cycle WINDOW_CYC+1.
- Latency for a transfer at cycle T:
  - `cell_in` at T+1;
  - `cell_clk` at T+2+SETUP_CYC;
  - window T+3+SETUP_CYC .. T+2+SETUP_CYC+WINDOW_CYC;
  - `rsp_valid` at T+3+SETUP_CYC+WINDOW_CYC.
  - With defaults: T+1, T+4, T+5..T+7, T+8.
- Next grant is possible at T+4+SETUP_CYC+WINDOW_CYC, i.e. the cycle after RESP. Throughput with defaults is one transaction per 9 cycles.
- `rsp_*` fields other than `rsp_valid` are 0 when `rsp_valid`=0.
- Simultaneous requests: exactly one grant per IDLE cycle. Dropping `req_valid` in IDLE without a transfer is legal.
- `rst` asserted mid-transaction:
  - the transaction is aborted with no response;
  - `cell_in` and `cell_clk` are forced to 0 the next cycle;
  - FLUSH reruns after release.

## Test plan
- Reset release, `cell_out` pulsed once at flush+1 → no `err_stray`; first grant available at cycle 4.
- Req 1 with data=0 at T, cell model pulses out at T+5 → `cell_in` stays 0, `cell_clk` at T+4, `rsp_valid` at T+8 with id=1, data=1, err=0.
- Req 2 with data=1, model pulses nothing → `cell_in`=1 at T+1, response id=2, data=0, err=0.
- All four requesters valid continuously → grants 0,1,2,3,0 at 9-cycle spacing. Then only req 3 is valid with pointer=1 → grant 3, pointer becomes 0.
- Model pulses out at both T+5 and T+6 → `rsp_err`=1, `rsp_data`=0. Separately, a pulse during IDLE → `err_stray`=1, which remains set through later transactions until `rst`.
- `rst` at T+3 of a transaction → no `rsp_valid`, `cell_clk` never issued for that transaction, flush `cell_clk` one cycle after release.
